// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement ROB with out-of-order completion and free-pool return
// ports: alloc_* dispatch request/fields, alloc_ready/rob_num allocation status and tag,
//        cmpl_valid/cmpl_rob_num per-port completion, retire_*/rob_push/rob_free_reg
//        registered retire pulses, count/empty occupancy
module reorder_buffer #(
  parameter int ENTRIES    = 64,
  parameter int PREG_WIDTH = 6,
  parameter int AREG_WIDTH = 5,
  parameter int PC_WIDTH   = 12,
  parameter int N_CMPL     = 3,
  localparam int IW        = $clog2(ENTRIES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alloc_valid,
  input  logic                   alloc_reg_write,
  input  logic [AREG_WIDTH-1:0]  alloc_rd,
  input  logic [PREG_WIDTH-1:0]  alloc_prd,
  input  logic [PREG_WIDTH-1:0]  alloc_old_prd,
  input  logic [PC_WIDTH-1:0]    alloc_pc,
  output logic                   alloc_ready,
  output logic [IW-1:0]          rob_num,
  input  logic [N_CMPL-1:0]      cmpl_valid,
  input  logic [N_CMPL*IW-1:0]   cmpl_rob_num,
  output logic                   rob_push,
  output logic [PREG_WIDTH-1:0]  rob_free_reg,
  output logic                   retire_valid,
  output logic [AREG_WIDTH-1:0]  retire_rd,
  output logic [PREG_WIDTH-1:0]  retire_prd,
  output logic [PC_WIDTH-1:0]    retire_pc,
  output logic [IW:0]            count,
  output logic                   empty
);
  localparam logic [IW:0] ONE = {{IW{1'b0}}, 1'b1};
  logic [IW:0]            r_head, r_tail;
  logic [ENTRIES-1:0]     r_valid, r_complete, r_reg_write;
  logic [AREG_WIDTH-1:0]  r_rd     [ENTRIES];
  logic [PREG_WIDTH-1:0]  r_prd    [ENTRIES];
  logic [PREG_WIDTH-1:0]  r_old_prd[ENTRIES];
  logic [PC_WIDTH-1:0]    r_pc     [ENTRIES];
  logic [IW-1:0]          w_h, w_t;
  logic                   w_alloc, w_retire;
  always_comb begin
    w_h         = r_head[IW-1:0];
    w_t         = r_tail[IW-1:0];
    count       = r_tail - r_head;
    empty       = r_tail == r_head;
    alloc_ready = ~count[IW];
    rob_num     = w_t;
    w_alloc     = alloc_valid & alloc_ready;
    w_retire    = r_valid[w_h] & r_complete[w_h];
  end
  // completion is applied first so a same-edge alloc of that slot clears it again
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_valid      <= '0;
      r_complete   <= '0;
      rob_push     <= 1'b0;
      rob_free_reg <= '0;
      retire_valid <= 1'b0;
      retire_rd    <= '0;
      retire_prd   <= '0;
      retire_pc    <= '0;
    end else begin
      for (int i = 0; i < N_CMPL; i++)
        if (cmpl_valid[i] && r_valid[cmpl_rob_num[IW*i +: IW]])
          r_complete[cmpl_rob_num[IW*i +: IW]] <= 1'b1;
      if (w_retire) begin
        r_valid[w_h] <= 1'b0;
        r_head       <= r_head + ONE;
        retire_rd    <= r_rd[w_h];
        retire_prd   <= r_prd[w_h];
        retire_pc    <= r_pc[w_h];
        rob_free_reg <= r_old_prd[w_h];
      end
      if (w_alloc) begin
        r_valid[w_t]    <= 1'b1;
        r_complete[w_t] <= 1'b0;
        r_tail          <= r_tail + ONE;
      end
      retire_valid <= w_retire;
      rob_push     <= w_retire & r_reg_write[w_h] & (|r_rd[w_h]);
    end
  always_ff @(posedge clk)
    if (w_alloc) begin
      r_reg_write[w_t] <= alloc_reg_write;
      r_rd[w_t]        <= alloc_rd;
      r_prd[w_t]       <= alloc_prd;
      r_old_prd[w_t]   <= alloc_old_prd;
      r_pc[w_t]        <= alloc_pc;
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: scoreboard bench for reorder_buffer
module tb_reorder_buffer;
  logic        clk = 0, rst = 1;
  logic        alloc_valid = 0, alloc_reg_write = 0;
  logic [4:0]  alloc_rd = 0;
  logic [5:0]  alloc_prd = 0, alloc_old_prd = 0;
  logic [11:0] alloc_pc = 0;
  logic        alloc_ready;
  logic [5:0]  rob_num;
  logic [2:0]  cmpl_valid = 0;
  logic [17:0] cmpl_rob_num = 0;
  logic        rob_push, retire_valid, empty;
  logic [5:0]  rob_free_reg, retire_prd;
  logic [4:0]  retire_rd;
  logic [11:0] retire_pc;
  logic [6:0]  count;
  int checks = 0, errors = 0;
  typedef struct {logic [4:0] rd; logic [5:0] prd; logic [11:0] pc; logic push; logic [5:0] fr;} exp_t;
  exp_t q[$];
  reorder_buffer dut (
    .clk(clk), .rst(rst), .alloc_valid(alloc_valid), .alloc_reg_write(alloc_reg_write),
    .alloc_rd(alloc_rd), .alloc_prd(alloc_prd), .alloc_old_prd(alloc_old_prd), .alloc_pc(alloc_pc),
    .alloc_ready(alloc_ready), .rob_num(rob_num), .cmpl_valid(cmpl_valid), .cmpl_rob_num(cmpl_rob_num),
    .rob_push(rob_push), .rob_free_reg(rob_free_reg), .retire_valid(retire_valid), .retire_rd(retire_rd),
    .retire_prd(retire_prd), .retire_pc(retire_pc), .count(count), .empty(empty)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk)
    if (!rst) begin
      if (retire_valid) begin
        if (q.size() == 0) chk("retire_extra", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("sb_rd", retire_rd, e.rd);
          chk("sb_prd", retire_prd, e.prd);
          chk("sb_pc", retire_pc, e.pc);
          chk("sb_push", rob_push, e.push);
          if (e.push) chk("sb_free", rob_free_reg, e.fr);
        end
      end else chk("push_idle", rob_push, 0);
    end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic alloc(input logic rw, input logic [4:0] rd, input logic [5:0] prd, old,
                       input logic [11:0] pc, output logic [5:0] tag);
    chk("alloc_ready", alloc_ready, 1);
    tag = rob_num;
    alloc_valid = 1; alloc_reg_write = rw; alloc_rd = rd;
    alloc_prd = prd; alloc_old_prd = old; alloc_pc = pc;
    q.push_back('{rd, prd, pc, rw && rd != 0, old});
    tick();
    alloc_valid = 0;
  endtask
  task automatic cmpl3(input logic [2:0] m, input logic [5:0] t0, t1, t2);
    cmpl_valid = m;
    cmpl_rob_num = {t2, t1, t0};
    tick();
    cmpl_valid = 0;
  endtask
  task automatic cmpl(input logic [5:0] t);
    cmpl3(3'b001, t, 0, 0);
  endtask
  task automatic drain(input int n);
    int k = 0;
    while ((count != 0 || q.size() != 0) && k < n) begin
      tick();
      k++;
    end
    chk("drain", {31'd0, count == 0 && q.size() == 0}, 1);
  endtask
  task automatic do_reset;
    rst = 1;
    #1;
    q.delete();
    tick();
    rst = 0;
  endtask
  logic [5:0] ta, tb, tc, tx, t;
  initial begin
    #2;
    rst = 0;
    tick();
    for (int i = 0; i < 5; i++) alloc(1, 5'(i + 1), 6'(i + 20), 6'(i), 12'(i), t);
    chk("pre_rst_count", count, 5);
    #2;
    rst = 1;
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ready", alloc_ready, 1);
    chk("rst_rob_num", rob_num, 0);
    chk("rst_push", rob_push, 0);
    chk("rst_rvalid", retire_valid, 0);
    q.delete();
    tick();
    rst = 0;
    alloc(1, 3, 40, 3, 12'h100, ta);
    cmpl(ta);
    chk("t2_early", retire_valid, 0);
    tick();
    chk("t2_rvalid", retire_valid, 1);
    chk("t2_prd", retire_prd, 40);
    chk("t2_push", rob_push, 1);
    chk("t2_free", rob_free_reg, 3);
    tick();
    chk("t2_pulse", retire_valid, 0);
    alloc(1, 1, 10, 1, 12'h1, ta);
    alloc(1, 2, 11, 2, 12'h2, tb);
    alloc(1, 4, 12, 4, 12'h3, tc);
    cmpl(tc);
    cmpl(tb);
    tick();
    chk("t3_wait", retire_valid, 0);
    chk("t3_count", count, 3);
    cmpl(ta);
    tick();
    chk("t3_a", retire_prd, 10);
    tick();
    chk("t3_b", retire_prd, 11);
    tick();
    chk("t3_c", retire_prd, 12);
    chk("t3_c_valid", retire_valid, 1);
    tick();
    chk("t3_done", retire_valid, 0);
    do_reset();
    for (int i = 0; i < 64; i++) alloc(1, 5'(i), 6'(i), 6'(63 - i), 12'(i), t);
    chk("t4_full_ready", alloc_ready, 0);
    chk("t4_full_count", count, 64);
    chk("t4_full_empty", empty, 0);
    alloc_valid = 1; alloc_rd = 31; alloc_prd = 33;
    tick();
    alloc_valid = 0;
    chk("t4_ignored_count", count, 64);
    chk("t4_ignored_tail", rob_num, 0);
    cmpl(0);
    chk("t4_still_full", alloc_ready, 0);
    tick();
    chk("t4_retired", retire_valid, 1);
    chk("t4_ready", alloc_ready, 1);
    chk("t4_count", count, 63);
    chk("t4_wrap", rob_num, 0);
    alloc(1, 7, 50, 20, 12'habc, t);
    chk("t4_tag", t, 0);
    chk("t4_tail_after", rob_num, 1);
    chk("t4_refull", count, 64);
    for (int i = 1; i < 64; i += 3) cmpl3(3'b111, 6'(i), 6'(i + 1), 6'(i + 2));
    cmpl(0);
    drain(200);
    alloc(1, 0, 21, 22, 12'h50, ta);
    alloc(0, 5, 23, 24, 12'h51, tb);
    tx = rob_num;
    chk("t5_ready", alloc_ready, 1);
    alloc_valid = 1; alloc_reg_write = 1; alloc_rd = 9; alloc_prd = 25; alloc_old_prd = 26; alloc_pc = 12'h52;
    q.push_back('{5'd9, 6'd25, 12'h52, 1'b1, 6'd26});
    cmpl_valid = 3'b001; cmpl_rob_num = {12'd0, tx};
    tick();
    alloc_valid = 0; cmpl_valid = 0;
    cmpl3(3'b011, ta, tb, 0);
    repeat (4) tick();
    chk("t5_same_cycle", count, 1);
    cmpl(tx);
    drain(20);
    do_reset();
    alloc(1, 6, 30, 31, 12'h60, ta);
    alloc(1, 8, 32, 33, 12'h61, tb);
    cmpl3(3'b111, 0, 1, 1);
    cmpl(9);
    for (int i = 2; i < 10; i++) alloc(1, 5'(i + 10), 6'(i + 40), 6'(i), 12'(i + 12'h70), t);
    cmpl3(3'b111, 2, 3, 4);
    cmpl3(3'b111, 5, 6, 7);
    cmpl(8);
    repeat (6) tick();
    chk("t6_nine_held", count, 1);
    chk("t6_tail", rob_num, 10);
    cmpl(9);
    drain(20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
